// File: rtl/bw_pkg.sv
// Shared helpers for the pipelined Baugh-Wooley multiplier: partial-product
// inversion rule and the signed-mode correction constant.
package bw_pkg;

    // Widest product the correction helper can describe.
    localparam int unsigned MAX_P_W = 64;

    // Inversion flag for partial product bit (i, j). In signed mode, a bit
    // whose weight carries exactly one operand sign bit is complemented.
    function automatic logic t_bit(input logic sgn, input int unsigned i,
                                   input int unsigned j, input int unsigned a_w,
                                   input int unsigned b_w);
        return sgn && ((i == a_w - 1) != (j == b_w - 1));
    endfunction

    // Correction constant for signed mode. Complementing the sign-weighted
    // rows leaves a bias of -(2^(P-1)) + 2^(A-1) + 2^(B-1) per the two
    // negative rows; modulo 2^P this is 2^(A-1) + 2^(B-1) + 2^(P-1). When
    // A_W == B_W the two low terms merge into a single 1 at column A_W.
    function automatic logic [MAX_P_W-1:0] bw_corr_vec(input int unsigned a_w,
                                                        input int unsigned b_w);
        logic [MAX_P_W-1:0] one;
        one = MAX_P_W'(1);
        return (one << (a_w - 1)) + (one << (b_w - 1)) + (one << (a_w + b_w - 1));
    endfunction

endpackage

// File: rtl/bw_pp_fa.sv
// One array cell: full adder whose first operand is the (possibly inverted)
// partial product bit (a & b) ^ t.
module bw_pp_fa (
    input  logic a,
    input  logic b,
    input  logic t,
    input  logic s,
    input  logic cin,
    output logic sum,
    output logic cout
);
    logic pp;

    assign pp   = (a & b) ^ t;
    assign sum  = pp ^ s ^ cin;
    assign cout = (pp & s) | (pp & cin) | (s & cin);

endmodule

// File: rtl/bw_mult_pipe.sv
// Pipelined Baugh-Wooley multiplier. Stage k folds multiplier row k into a
// carry-save (sum, carry) pair; a final stage resolves the pair into out_p.
// Handshake: a beat moves on in_valid & in_ready and leaves on
// out_valid & out_ready; the whole pipe advances together when
// adv = !out_valid | out_ready, and in_ready is exactly adv.
module bw_mult_pipe
    import bw_pkg::*;
#(
    parameter int  A_W = 7,
    parameter int  B_W = 5,
    localparam int P_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_signed,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [P_W-1:0] out_p,
    output logic           out_signed
);

    // Stage record carried between pipeline registers.
    typedef struct packed {
        logic [P_W-1:0] sum;
        logic [P_W-1:0] carry;
        logic [A_W-1:0] a;
        logic [B_W-1:0] b;
        logic           sgn;
        logic           valid;
    } stage_t;

    localparam logic [MAX_P_W-1:0] CORR_FULL = bw_corr_vec(A_W, B_W);
    localparam logic [P_W-1:0]     CORR      = CORR_FULL[P_W-1:0];

    logic   adv;
    stage_t head;
    stage_t last;
    logic [P_W-1:0] total;
    logic   unused_tail;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Incoming beat seeds the carry-save pair with the mode's constant.
    always_comb begin
        head       = '0;
        head.sum   = in_signed ? CORR : '0;
        head.a     = in_a;
        head.b     = in_b;
        head.sgn   = in_signed;
        head.valid = in_valid;
    end

    for (genvar k = 0; k < B_W; k++) begin : g_stage
        stage_t         prev;
        stage_t         nxt;
        stage_t         q;
        logic [P_W-1:0] cell_sum;
        logic [P_W-1:0] cell_cout;
        logic           unused_cout;

        if (k == 0) begin : g_first
            assign prev = head;
        end else begin : g_next
            assign prev = g_stage[k-1].q;
        end

        for (genvar c = 0; c < P_W; c++) begin : g_col
            if (c >= k && c - k < A_W) begin : g_pp
                logic t;
                assign t = t_bit(prev.sgn, c - k, k, A_W, B_W);
                bw_pp_fa u_fa (
                    .a   (prev.a[c-k]),
                    .b   (prev.b[k]),
                    .t   (t),
                    .s   (prev.sum[c]),
                    .cin (prev.carry[c]),
                    .sum (cell_sum[c]),
                    .cout(cell_cout[c])
                );
            end else begin : g_pass
                bw_pp_fa u_fa (
                    .a   (1'b0),
                    .b   (1'b0),
                    .t   (1'b0),
                    .s   (prev.sum[c]),
                    .cin (prev.carry[c]),
                    .sum (cell_sum[c]),
                    .cout(cell_cout[c])
                );
            end
        end

        // Carries move one column left; the carry out of the top column is
        // beyond the product width and is dropped.
        assign unused_cout = cell_cout[P_W-1];

        // Next-stage record: operands and mode ride along, sum/carry update.
        always_comb begin
            nxt       = prev;
            nxt.sum   = cell_sum;
            nxt.carry = {cell_cout[P_W-2:0], 1'b0};
        end

        // Stage register; holds (bubbles included) while the output stalls.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= '0;
            end else if (adv) begin
                q <= nxt;
            end
        end
    end

    assign last        = g_stage[B_W-1].q;
    assign total       = last.sum + last.carry;
    assign unused_tail = ^{last.a, last.b};

    // Carry-propagate stage; bubbles present a zero product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_p      <= '0;
            out_signed <= 1'b0;
        end else if (adv) begin
            out_valid  <= last.valid;
            out_p      <= last.valid ? total : '0;
            out_signed <= last.valid ? last.sgn : 1'b0;
        end
    end

endmodule

// File: tb/tb_bw_mult_pipe.sv
// Scoreboard bench for bw_mult_pipe: drivers push expected products into
// queues, monitors pop and compare when the DUT presents a beat.
module tb_bw_mult_pipe;

    localparam int A_W = 7;
    localparam int B_W = 5;
    localparam int P_W = A_W + B_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Clock and edge counter.
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default-width DUT.
    logic           in_valid, in_ready, in_signed;
    logic [A_W-1:0] in_a;
    logic [B_W-1:0] in_b;
    logic           out_valid, out_ready, out_signed;
    logic [P_W-1:0] out_p;

    bw_mult_pipe #(.A_W(A_W), .B_W(B_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .out_valid(out_valid),
        .out_ready(out_ready), .out_p(out_p), .out_signed(out_signed)
    );

    // Sweep DUT 4x4.
    logic       s44_valid, s44_ready, s44_sgn, s44_ovalid, s44_oready, s44_osgn;
    logic [3:0] s44_a, s44_b;
    logic [7:0] s44_p;

    bw_mult_pipe #(.A_W(4), .B_W(4)) dut44 (
        .clk(clk), .rst_n(rst_n), .in_valid(s44_valid), .in_ready(s44_ready),
        .in_signed(s44_sgn), .in_a(s44_a), .in_b(s44_b), .out_valid(s44_ovalid),
        .out_ready(s44_oready), .out_p(s44_p), .out_signed(s44_osgn)
    );

    // Sweep DUT 8x3.
    logic        s83_valid, s83_ready, s83_sgn, s83_ovalid, s83_oready, s83_osgn;
    logic [7:0]  s83_a;
    logic [2:0]  s83_b;
    logic [10:0] s83_p;

    bw_mult_pipe #(.A_W(8), .B_W(3)) dut83 (
        .clk(clk), .rst_n(rst_n), .in_valid(s83_valid), .in_ready(s83_ready),
        .in_signed(s83_sgn), .in_a(s83_a), .in_b(s83_b), .out_valid(s83_ovalid),
        .out_ready(s83_oready), .out_p(s83_p), .out_signed(s83_osgn)
    );

    // Scoreboard queues: {mode, product}, accept edge, latency-check flag.
    logic [P_W:0] exp_q[$];
    int           acc_q[$];
    bit           lat_q[$];
    int           del_log[$];
    logic [8:0]   exp44_q[$];
    int           acc44_q[$];
    logic [11:0]  exp83_q[$];
    int           acc83_q[$];
    bit           sw_go = 1'b0;
    bit           s44_done = 1'b0;
    bit           s83_done = 1'b0;
    int           stall_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: interpret operands per mode, multiply, wrap to product width.
    function automatic logic [63:0] ref_prod(input int a, input int b, input bit s,
                                             input int aw, input int bw);
        longint sa, sb, p;
        sa = a;
        sb = b;
        if (s) begin
            if (a >= (1 << (aw - 1))) sa = a - (1 << aw);
            if (b >= (1 << (bw - 1))) sb = b - (1 << bw);
        end
        p = sa * sb;
        return 64'(p) & ((64'd1 << (aw + bw)) - 64'd1);
    endfunction

    // Driver: present a beat from a falling edge until in_ready lets it in.
    task automatic send(input int a, input int b, input bit s, input bit chk_lat);
        int n = 0;
        in_valid  = 1'b1;
        in_a      = A_W'(a);
        in_b      = B_W'(b);
        in_signed = s;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=blocked required=accepted");
        end else begin
            exp_q.push_back({s, P_W'(ref_prod(a, b, s, A_W, B_W))});
            acc_q.push_back(cyc + 1);
            lat_q.push_back(chk_lat);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // Monitor for the default DUT: handshake, stall stability, scoreboard.
    logic           prev_stall = 1'b0;
    logic [P_W-1:0] prev_p;
    logic           prev_s;
    always @(negedge clk) begin
        logic [P_W:0] e;
        int           a;
        bit           l;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (!out_valid) check("bubble_p_zero", out_p, 0);
            if (prev_stall) begin
                stall_seen++;
                check("stall_valid", out_valid, 1);
                check("stall_p", out_p, prev_p);
                check("stall_mode", out_signed, prev_s);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%0h required=no_beat", out_p);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    l = lat_q.pop_front();
                    check("product", out_p, e[P_W-1:0]);
                    check("mode", out_signed, e[P_W]);
                    if (l) check("latency", cyc + 1 - a, B_W + 1);
                    del_log.push_back(cyc + 1);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_p     = out_p;
            prev_s     = out_signed;
        end
    end

    // Exhaustive driver for the 4x4 instance.
    initial begin
        s44_valid = 1'b0; s44_a = '0; s44_b = '0; s44_sgn = 1'b0; s44_oready = 1'b1;
        wait (sw_go);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    s44_valid = 1'b1; s44_a = 4'(a); s44_b = 4'(b); s44_sgn = 1'(s);
                    if (s44_ready) begin
                        exp44_q.push_back({1'(s), 8'(ref_prod(a, b, 1'(s), 4, 4))});
                        acc44_q.push_back(cyc + 1);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL s44_ready actual=0 required=1");
                    end
                    @(negedge clk);
                end
            end
        end
        s44_valid = 1'b0;
        s44_done  = 1'b1;
    end

    // Monitor for the 4x4 instance.
    always @(negedge clk) begin
        logic [8:0] e;
        int         a;
        if (rst_n && s44_ovalid) begin
            if (exp44_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s44_unexpected actual=%0h required=no_beat", s44_p);
            end else begin
                e = exp44_q.pop_front();
                a = acc44_q.pop_front();
                check("s44_product", s44_p, e[7:0]);
                check("s44_mode", s44_osgn, e[8]);
                check("s44_latency", cyc + 1 - a, 5);
            end
        end
    end

    // Exhaustive driver for the 8x3 instance.
    initial begin
        s83_valid = 1'b0; s83_a = '0; s83_b = '0; s83_sgn = 1'b0; s83_oready = 1'b1;
        wait (sw_go);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 256; a++) begin
                for (int b = 0; b < 8; b++) begin
                    s83_valid = 1'b1; s83_a = 8'(a); s83_b = 3'(b); s83_sgn = 1'(s);
                    if (s83_ready) begin
                        exp83_q.push_back({1'(s), 11'(ref_prod(a, b, 1'(s), 8, 3))});
                        acc83_q.push_back(cyc + 1);
                    end else begin
                        checks++;
                        errors++;
                        $display("FAIL s83_ready actual=0 required=1");
                    end
                    @(negedge clk);
                end
            end
        end
        s83_valid = 1'b0;
        s83_done  = 1'b1;
    end

    // Monitor for the 8x3 instance.
    always @(negedge clk) begin
        logic [11:0] e;
        int          a;
        if (rst_n && s83_ovalid) begin
            if (exp83_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL s83_unexpected actual=%0h required=no_beat", s83_p);
            end else begin
                e = exp83_q.pop_front();
                a = acc83_q.pop_front();
                check("s83_product", s83_p, e[10:0]);
                check("s83_mode", s83_osgn, e[11]);
                check("s83_latency", cyc + 1 - a, 4);
            end
        end
    end

    // Watchdog.
    initial begin
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Main sequence.
    initial begin
        int n;
        int quiet_valid;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; out_ready = 1'b1;

        // Reset state.
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_out_signed", out_signed, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);
        check("post_rst_out_valid", out_valid, 0);

        // Signed -64 x -16 with latency check.
        send(64, 16, 1'b1, 1'b1);
        wait_drain();

        // Signed 63x15 then -64x15 back to back.
        del_log.delete();
        send(63, 15, 1'b1, 1'b1);
        send(64, 15, 1'b1, 1'b1);
        wait_drain();
        check("b2b_count", del_log.size(), 2);
        if (del_log.size() == 2) check("b2b_gap", del_log[1] - del_log[0], 1);

        // Unsigned 127x31 then signed 127x31: mode isolation.
        del_log.delete();
        send(127, 31, 1'b0, 1'b1);
        send(127, 31, 1'b1, 1'b1);
        wait_drain();
        check("mode_b2b_count", del_log.size(), 2);
        if (del_log.size() == 2) check("mode_b2b_gap", del_log[1] - del_log[0], 1);

        // Random stream of 20 with an output stall window.
        stall_seen = 0;
        fork
            begin
                for (int i = 0; i < 20; i++)
                    send($urandom_range(0, 127), $urandom_range(0, 31),
                         1'($urandom_range(0, 1)), 1'b0);
            end
            begin
                repeat (8) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("stall_exercised", stall_seen > 0, 1);

        // Reset with four beats in flight, output stalled.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i + 3, i + 7, 1'(i % 2), 1'b0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("pre_rst_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_p", out_p, 0);
        check("async_rst_mode", out_signed, 0);
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        quiet_valid = 0;
        repeat (15) begin
            @(negedge clk);
            if (out_valid) quiet_valid++;
        end
        check("no_spurious_out", quiet_valid, 0);
        send(5, 3, 1'b0, 1'b1);
        wait_drain();

        // Exhaustive sweeps on the alternate widths.
        sw_go = 1'b1;
        n = 0;
        while (!(s44_done && s83_done && exp44_q.size() == 0 && exp83_q.size() == 0)
               && n < 10000) begin
            @(negedge clk);
            n++;
        end
        check("sweep_done", s44_done && s83_done, 1);
        check("sweep44_drain", exp44_q.size(), 0);
        check("sweep83_drain", exp83_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
